// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with parity/framing/overrun flags and a valid/ready held output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around every bit mid-point.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_Rx_Data,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_Valid,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam logic [TICK_W-1:0] START_END = TICK_W'(OVERSAMPLE / 2 - 1 + MAJ);
    localparam logic [TICK_W-1:0] BIT_END   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic              ODD       = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT} state_t;
    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, samp, bit_end, complete, frame_err;
    logic [TICK_W-1:0]      tick;
    logic [BIT_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift, pend_byte;
    logic                   perr, ferr, done, pend_perr, pend_ferr;

    always_ff @(posedge clk)
        sync <= reset ? '1 : {sync[SYNC_STAGES-2:0], i_Rx_Data};

    assign rx_s = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // hist[1], hist[0], rx_s are the mid-1, mid, mid+1 samples at the decision cycle
    logic [1:0] hist;
    always_ff @(posedge clk)
        hist <= reset ? 2'b11 : {hist[0], rx_s};
    assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign samp = rx_s;
`endif

    assign bit_end   = tick == BIT_END;
    assign frame_err = ferr | ~samp;

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (!rx_s) state_n = S_START;
            S_START:      if (tick == START_END) state_n = samp ? S_IDLE : S_DATA;
            S_DATA:       if (bit_end && bit_idx == LAST_DATA) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:     if (bit_end) state_n = S_STOP;
            S_STOP:       if (bit_end && bit_idx == LAST_STOP) state_n = (frame_err && !rx_s) ? S_BREAK_WAIT : S_IDLE;
            S_BREAK_WAIT: if (rx_s) state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    always_comb begin
        o_Busy   = state != S_IDLE;
        complete = state == S_STOP && bit_end && bit_idx == LAST_STOP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            done      <= 1'b0;
            pend_byte <= '0;
            pend_perr <= 1'b0;
            pend_ferr <= 1'b0;
        end else begin
            tick    <= (state == S_IDLE || state_n != state || bit_end) ? '0 : tick + 1'b1;
            bit_idx <= (state_n != state) ? '0 : bit_idx + BIT_W'(bit_end);
            if (state == S_DATA && bit_end)
                shift <= {samp, shift[DATA_BITS-1:1]};
            perr <= (state == S_IDLE) ? 1'b0 : (state == S_PARITY && bit_end) ? ((^shift ^ samp) != ODD) : perr;
            ferr <= (state == S_IDLE) ? 1'b0 : (state == S_STOP && bit_end && !samp) ? 1'b1 : ferr;
            done <= complete;
            if (complete) begin
                pend_byte <= shift;
                pend_perr <= perr;
                pend_ferr <= frame_err;
            end
        end
    end

    // a completed frame is only taken if the held slot is free or being consumed this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            o_Rx_Valid   <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;
        end else if (done && (!o_Rx_Valid || i_Rx_Ready)) begin
            o_Rx_Valid   <= 1'b1;
            o_Rx_Byte    <= pend_byte;
            o_Parity_Err <= pend_perr;
            o_Frame_Err  <= pend_ferr;
            o_Overrun    <= 1'b0;
        end else if (done) begin
            o_Overrun <= 1'b1;
        end else if (o_Rx_Valid && i_Rx_Ready) begin
            o_Rx_Valid <= 1'b0;
            o_Overrun  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param (8 data bits, even parity, 1 stop, x16).
module tb_uart_rx_param;
    localparam int DB = 8, OS = 16, PAR = 2, SB = 1, SS = 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT = SS + 1 + OS / 2 + (DB + 1 + SB) * OS + 1 + MAJ;
    localparam int FS_LIM = OS / 2 + SS + 2;

    logic          clk = 0, reset = 1, i_Rx_Data = 1, i_Rx_Ready = 0;
    logic          o_Rx_Valid, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy;
    logic [DB-1:0] o_Rx_Byte;
    int            checks = 0, failures = 0;
    logic [10:0]   exp_q[$];

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(PAR), .STOP_BITS(SB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .i_Rx_Data(i_Rx_Data), .i_Rx_Ready(i_Rx_Ready),
        .o_Rx_Valid(o_Rx_Valid), .o_Rx_Byte(o_Rx_Byte), .o_Parity_Err(o_Parity_Err),
        .o_Frame_Err(o_Frame_Err), .o_Overrun(o_Overrun), .o_Busy(o_Busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // frame on the wire: start 0, data LSB first, even parity (optionally flipped), stop 1
    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, ^d ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            i_Rx_Data = bits[i];
            cycles(OS);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4 * LAT) begin
            cycles(1);
            t++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // expected entry layout: {overrun, frame_err, parity_err, byte}, checked when the byte is consumed
    always @(negedge clk) begin
        if (!reset && o_Rx_Valid && i_Rx_Ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got byte 0x%0h with no frame expected", o_Rx_Byte);
            end else
                chk("frame", {o_Overrun, o_Frame_Err, o_Parity_Err, o_Rx_Byte}, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, stable, t;
        logic        saw, bp;
        logic [7:0]  d;
        logic [10:0] bits;
        cycles(2);
        chk("reset_outputs", {o_Rx_Valid, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy}, 0);
        reset = 0;
        cycles(4);

        exp_q.push_back({3'b000, 8'hA5});
        lat = 0;
        fork
            send_frame(8'hA5, 1'b0);
            while (!o_Rx_Valid && lat < 4 * LAT) begin
                cycles(1);
                lat++;
            end
        join
        chk("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
        stable = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_Rx_Valid && o_Rx_Byte == 8'hA5 && !o_Parity_Err && !o_Frame_Err && !o_Overrun) stable++;
        end
        chk("hold_stable", stable, 100);
        @(posedge clk);
        #1;
        i_Rx_Ready = 1;
        cycles(1);
        i_Rx_Ready = 0;
        chk("valid_drop_after_ack", o_Rx_Valid, 0);
        chk("drain_a5", exp_q.size(), 0);

        i_Rx_Ready = 1;
        exp_q.push_back({3'b001, 8'h01});
        send_frame(8'h01, 1'b1);
        wait_drain("drain_parity");

        exp_q.push_back({3'b010, 8'h00});
        i_Rx_Data = 0;
        cycles(12 * OS);
        chk("break_busy", o_Busy, 1);
        chk("drain_break", exp_q.size(), 0);
        i_Rx_Data = 1;
        cycles(SS + 2);
        chk("break_idle", o_Busy, 0);
        cycles(3 * OS);
        chk("break_no_second", exp_q.size(), 0);

        i_Rx_Ready = 0;
        saw = 0;
        t = 0;
        lat = -1;
        i_Rx_Data = 0;
        repeat (3 * OS) begin
            cycles(1);
            t++;
            if (t == 4) i_Rx_Data = 1;
            if (o_Busy) saw = 1;
            else if (saw && lat < 0) lat = t;
        end
        chk("false_start_busy_seen", saw, 1);
        chk("false_start_drop_cycle", (lat > 0 && lat <= FS_LIM) ? FS_LIM : lat, FS_LIM);
        chk("false_start_no_valid", o_Rx_Valid, 0);

        exp_q.push_back({3'b100, 8'h11});
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        cycles(4);
        chk("ovr_held_byte", o_Rx_Byte, 8'h11);
        chk("ovr_flag", {o_Rx_Valid, o_Overrun}, 2'b11);
        i_Rx_Ready = 1;
        cycles(1);
        i_Rx_Ready = 0;
        chk("ovr_cleared", {o_Rx_Valid, o_Overrun}, 0);
        chk("drain_ovr", exp_q.size(), 0);
        i_Rx_Ready = 1;
        exp_q.push_back({3'b000, 8'h33});
        send_frame(8'h33, 1'b0);
        wait_drain("drain_33");

        i_Rx_Ready = 0;
        send_frame(8'h77, 1'b0);
        cycles(4);
        chk("pre_reset_valid", o_Rx_Valid, 1);
        d = 8'h5A;
        bits = {1'b1, ^d, d, 1'b0};
        for (int i = 0; i < 5; i++) begin
            i_Rx_Data = bits[i];
            cycles(i == 4 ? OS / 2 : OS);
        end
        chk("mid_frame_busy", o_Busy, 1);
        reset = 1;
        cycles(1);
        chk("reset_mid_frame", {o_Rx_Valid, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy}, 0);
        reset = 0;
        i_Rx_Data = 1;
        cycles(2 * OS);
        chk("post_reset_idle", {o_Rx_Valid, o_Busy}, 0);
        i_Rx_Ready = 1;
        exp_q.push_back({3'b000, 8'h3C});
        send_frame(8'h3C, 1'b0);
        wait_drain("drain_3c");

        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            exp_q.push_back({2'b00, bp, d});
            send_frame(d, bp);
            cycles($urandom_range(0, 2 * OS));
        end
        wait_drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
